uart_rx_oversampled: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/uart_rx_oversampled.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the
// clocks-per-tick helper used by the receiver and the baud tick generator.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_e;

  // Clocks per oversampling tick (integer floor).
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
// Counts 0..DIVISOR-1 and raises Tick for one clock while the count sits at
// DIVISOR-1. Clear restarts the count at 0 so the tick phase follows an edge.
// Ports:
//   CLK_100MHz  in   system clock
//   Reset       in   asynchronous active-high reset
//   Clear       in   restart the divider
//   Tick        out  one-cycle pulse every DIVISOR clocks
module uart_baud_tick #(
  parameter int unsigned DIVISOR = 54
) (
  input  logic CLK_100MHz,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it is high while cnt_q == last.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (Clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    tick_d = !Clear && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign Tick = tick_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling, mid-bit sampling, start-glitch
// rejection, stop-bit check and a single-entry valid/ready holding register.
// Optional parity: define UART_RX_PARITY_EN to insert a PARITY state between
// DATA and STOP, enable parameter PARITY_ODD and port ParityError.
// Ports:
//   CLK_100MHz   in   system clock
//   Reset        in   asynchronous active-high reset
//   Rx           in   asynchronous serial line, idles high
//   RxData       out  received byte, valid while RxValid
//   RxValid      out  holding register full
//   RxReady      in   consumer takes the byte when RxValid & RxReady
//   FrameError   out  one-cycle pulse, stop bit sampled low
//   Overrun      out  one-cycle pulse, completed byte dropped (register full)
//   Busy         out  receiver not idle
//   ParityError  out  (parity build) one-cycle pulse, parity mismatch
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic                 CLK_100MHz,
  input  logic                 Reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  input  logic                 RxReady,
  output logic                 FrameError,
  output logic                 Overrun,
  output logic                 Busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 ParityError
`endif
);

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TCNT_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W  = $clog2(DATA_BITS);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  // Input synchronizer; both stages reset to the idle (high) level.
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], Rx};
    end
  end

  assign rx_s = sync_q[1];

  // Oversampling tick, re-phased on every accepted start edge.
  logic tick;
  logic tick_clr_c;

  uart_baud_tick #(
    .DIVISOR (DIVISOR)
  ) u_baud_tick (
    .CLK_100MHz (CLK_100MHz),
    .Reset      (Reset),
    .Clear      (tick_clr_c),
    .Tick       (tick)
  );

  state_e               state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 done_c;
  logic                 ferr_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_c;
`endif

  // Frame sequencing: ticks are counted per state; samples land mid-bit.
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    tick_clr_c = 1'b0;
    done_c     = 1'b0;
    ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    perr_c     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_clr_c = 1'b1;
          tcnt_d     = '0;
          bcnt_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_q == TCNT_MID) begin
            tcnt_d  = '0;
            // Line back high at mid start bit means it was only a glitch.
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == BCNT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d    = '0;
            par_bad_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
            state_d   = STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            // Return to IDLE at mid stop bit so a back-to-back start is seen.
            tcnt_d  = '0;
            state_d = IDLE;
            ferr_c  = !rx_s;
`ifdef UART_RX_PARITY_EN
            perr_c  = par_bad_q;
            done_c  = rx_s && !par_bad_q;
`else
            done_c  = rx_s;
`endif
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Holding register and status outputs.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  // A full register that is being drained in the same cycle can take the
  // new byte; otherwise the new byte is dropped and the old one kept.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_c;
    ovr_d   = 1'b0;
    busy_d  = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_c;
`endif
    if (done_c) begin
      if (!valid_q || RxReady) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && RxReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_100MHz or posedge Reset) begin
    if (Reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign RxData     = data_q;
  assign RxValid    = valid_q;
  assign FrameError = ferr_q;
  assign Overrun    = ovr_q;
  assign Busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign ParityError = perr_q;
`endif

endmodule
